// File: rtl/alu_sequencer.sv
// alu_sequencer: runs one register-register instruction at a time on the shared
// datapath. Owns the single reg_file port (read rs1, read rs2, write rd) and drives
// the combinational ALU from latched operands. Completion is signalled by a
// one-cycle done pulse, qualified by err for illegal opcodes.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              reg_rw,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data_in,
  input  logic [DATA_W-1:0] reg_data_out,
  output logic [DATA_W-1:0] alu_reg_1,
  output logic [DATA_W-1:0] alu_reg_2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  localparam logic [OP_W-1:0] OP_SLT = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LI  = OP_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_LAT,
    S_WB
  } state_t;

  state_t              state;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   rs1_q;
  logic [ADDR_W-1:0]   rs2_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   op2_q;
  logic [DATA_W-1:0]   result_q;
  logic                done_q;
  logic                err_q;

  logic                in_is_alu;
  logic                q_is_li;
  logic                q_is_illegal;
  logic [DATA_W-1:0]   wb_data;

  // Opcodes 0..4 go through the ALU, 15 loads the immediate, the rest are illegal.
  assign in_is_alu    = (instr_op <= OP_SLT);
  assign q_is_li      = (op_q == OP_LI);
  assign q_is_illegal = !(op_q <= OP_SLT) && !q_is_li;
  assign wb_data      = q_is_li ? imm_q : alu_out;

  assign instr_ready = (state == S_IDLE);
  assign alu_reg_1   = op1_q;
  assign alu_reg_2   = op2_q;
  assign alu_op      = op_q;
  assign done        = done_q;
  assign err         = err_q;
  assign result      = result_q;

  // Sequencer FSM: accept, walk the read/latch/write slots, retire with a done pulse.
  // Illegal opcodes take the write slot with the write suppressed, so their
  // latency matches LI and instr_ready stays low until done is raised.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            imm_q <= instr_imm;
            state <= in_is_alu ? S_RD1 : S_WB;
          end
        end
        S_RD1: state <= S_RD2;
        S_RD2: begin
          op1_q <= reg_data_out;
          state <= S_LAT;
        end
        S_LAT: begin
          op2_q <= reg_data_out;
          state <= S_WB;
        end
        S_WB: begin
          done_q <= 1'b1;
          if (q_is_illegal) begin
            err_q <= 1'b1;
          end else begin
            result_q <= wb_data;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register-file port decode from registered state only; reset forces IDLE, so
  // reg_rw drops asynchronously and no write can happen during reset.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    reg_rw      = 1'b0;
    reg_addr    = '0;
    reg_data_in = '0;
    case (state)
      S_RD1: reg_addr = rs1_q;
      S_RD2: reg_addr = rs2_q;
      S_WB: begin
        reg_addr = rd_q;
        if (!q_is_illegal) begin
          reg_rw      = 1'b1;
          reg_data_in = wb_data;
        end
      end
      default: ;
    endcase
  end

endmodule
